// File: rtl/pi_cmd_pkg.sv
// rtl/pi_cmd_pkg.sv - shared types and codes for the Pi command receiver
package pi_cmd_pkg;

   localparam int PI_BUS_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      BUSY,
      ACK,
      ERR
   } state_e;

   localparam logic [1:0] AMT_SMALL   = 2'b00;
   localparam logic [1:0] AMT_MED     = 2'b01;
   localparam logic [1:0] AMT_LARGE   = 2'b10;
   localparam logic [1:0] AMT_INVALID = 2'b11;

   localparam logic [2:0] MODE_STOP = 3'b000;

   typedef struct packed {
      logic       req;
      logic [1:0] amount;
      logic [2:0] mode;
   } pi_bus_t;

endpackage

// File: rtl/pi_cmd_receiver_if.sv
// rtl/pi_cmd_receiver_if.sv - dispense command handshake towards the motor stage
interface pi_cmd_receiver_if;

   logic [2:0] cmd_mode;
   logic [1:0] cmd_amount;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_done;

   modport master (
      output cmd_mode,
      output cmd_amount,
      output cmd_valid,
      input  cmd_ready,
      input  cmd_done
   );

   modport slave (
      input  cmd_mode,
      input  cmd_amount,
      input  cmd_valid,
      output cmd_ready,
      output cmd_done
   );

endinterface

// File: rtl/pi_cmd_receiver_bus_debounce.sv
// rtl/pi_cmd_receiver_bus_debounce.sv - synchroniser and whole-bus stability filter
module bus_debounce #(
   parameter int W             = 6,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1040,
   parameter int STABLE_W      = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [W-1:0] dout_next
);

   localparam logic [STABLE_W-1:0] CNT_LAST = STABLE_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
   logic [STABLE_W-1:0]           cnt_q, cnt_d;
   logic [W-1:0]                  deb_q, deb_d;
   logic                          change;

   // Change is seen as the value entering the last stage, so the counter
   // restarts on the same edge the synchronised bus takes the new value.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      change = (sync_q[SYNC_STAGES-1] != sync_q[SYNC_STAGES-2]);
      cnt_d  = cnt_q;
      deb_d  = deb_q;
      if (change) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + STABLE_W'(1);
      end else begin
         deb_d = sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         deb_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

   assign dout      = deb_q;
   assign dout_next = deb_d;

endmodule

// File: rtl/pi_cmd_receiver.sv
// rtl/pi_cmd_receiver.sv - Pi request/ack front-end issuing one dispense command per request
module pi_cmd_receiver
   import pi_cmd_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 1040,
   parameter int STABLE_W       = 11,
   parameter int TIMEOUT_CYCLES = 20800000,
   parameter int TIMEOUT_W      = 25
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         mode_in,
   input  logic [1:0]         amount_in,
   input  logic               req_in,
   pi_cmd_receiver_if.master  cmd_if,
   output logic [2:0]         jog_mode,
   output logic               ack_out,
   output logic               err_out,
   output logic               busy
);

   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   pi_bus_t bus_in, deb_q, deb_next;

   state_e               state_q, state_d;
   logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
   logic [2:0]           cmd_mode_q, cmd_mode_d, jog_q, jog_d;
   logic [1:0]           cmd_amount_q, cmd_amount_d;
   logic                 cmd_valid_q, cmd_valid_d;
   logic                 ack_q, ack_d, err_q, err_d, busy_q, busy_d;
   logic                 unused_next_amount;

   assign bus_in = {req_in, amount_in, mode_in};

   bus_debounce #(
      .W             (PI_BUS_W),
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .STABLE_W      (STABLE_W)
   ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .din       (bus_in),
      .dout      (deb_q),
      .dout_next (deb_next)
   );

   assign unused_next_amount = ^deb_next.amount;

   always_comb begin
      state_d      = state_q;
      tmo_d        = '0;
      cmd_mode_d   = cmd_mode_q;
      cmd_amount_d = cmd_amount_q;
      unique case (state_q)
         IDLE: begin
            if (deb_q.req) begin
               if (deb_q.amount == AMT_INVALID) begin
                  state_d = ERR;
               end else begin
                  state_d      = ISSUE;
                  cmd_mode_d   = deb_q.mode;
                  cmd_amount_d = deb_q.amount;
               end
            end
         end
         ISSUE: if (cmd_valid_q && cmd_if.cmd_ready) state_d = BUSY;
         // cmd_done takes priority over an expiring timeout
         BUSY: begin
            if (cmd_if.cmd_done)      state_d = ACK;
            else if (tmo_q == TMO_LAST) state_d = ERR;
            else                      tmo_d   = tmo_q + TIMEOUT_W'(1);
         end
         ACK, ERR: if (!deb_q.req) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cmd_valid_d = (state_d == ISSUE);
      ack_d       = (state_d == ACK);
      err_d       = (state_d == ERR);
      busy_d      = (state_d != IDLE);
      // Jog looks at the debounced value being loaded this edge so it
      // appears together with the deb_* update.
      jog_d = (state_d == IDLE && !deb_next.req) ? deb_next.mode : MODE_STOP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         tmo_q        <= '0;
         cmd_mode_q   <= '0;
         cmd_amount_q <= '0;
         cmd_valid_q  <= 1'b0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         jog_q        <= MODE_STOP;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         cmd_mode_q   <= cmd_mode_d;
         cmd_amount_q <= cmd_amount_d;
         cmd_valid_q  <= cmd_valid_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         jog_q        <= jog_d;
      end
   end

   assign cmd_if.cmd_mode   = cmd_mode_q;
   assign cmd_if.cmd_amount = cmd_amount_q;
   assign cmd_if.cmd_valid  = cmd_valid_q;
   assign jog_mode          = jog_q;
   assign ack_out           = ack_q;
   assign err_out           = err_q;
   assign busy              = busy_q;

endmodule

// File: doc/pi_cmd_receiver.md
# pi_cmd_receiver

Upstream command front-end for the candy dispenser. It synchronises and debounces the asynchronous Raspberry Pi GPIO lines (mode bits, amount bits, candyflag request) and runs the four-phase request/acknowledge protocol with the Pi. It issues one validated dispense command per request to the downstream motor-control stage over a valid/ready handshake. It also passes a debounced jog/test mode to the motor stage while no dispense is in progress.

## Interface
- SYNC_STAGES, 2: synchroniser depth on every Pi input (minimum 2).
- STABLE_CYCLES, 1040: number of cycles the synchronised bus must hold unchanged before it is accepted (0.5 ms at 2.08 MHz).
- STABLE_W, 11: width of the stability counter; must hold STABLE_CYCLES-1.
- TIMEOUT_CYCLES, 20800000: maximum BUSY duration (10 s at 2.08 MHz).
- TIMEOUT_W, 25: width of the timeout counter.

Ports:
- clk  in  1  internal oscillator clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- mode_in  in  3  async Pi test-state bits.
- amount_in  in  2  async Pi amount code.
- req_in  in  1  async Pi candyflag request.
- cmd_mode  out  3  latched mode for the issued command.
- cmd_amount  out  2  latched amount for the issued command.
- cmd_valid  out  1  command offered to downstream.
- cmd_ready  in  1  downstream accepts the command.
- cmd_done  in  1  single-cycle pulse when the dispense has completed.
- jog_mode  out  3  debounced manual mode; 3'b000 means stop.
- ack_out  out  1  handshake to the Pi.
- err_out  out  1  invalid-amount or timeout flag to the Pi.
- busy  out  1  high in every state except IDLE.

## Operation
- Bus: {req, amount[1:0], mode[2:0]}, 6 bits. Each bit passes through SYNC_STAGES flops, all reset to 0.
- Debounce:
  - The stability counter clears on any change of the synchronised bus and otherwise increments, saturating at STABLE_CYCLES-1.
  - The deb_* registers load the synchronised bus on the cycle the counter equals STABLE_CYCLES-1 with no change.
- Amount codes: 00 small, 01 medium, 10 large, 11 invalid.
- FSM states:
  - IDLE: if deb_req=1 and deb_amount≠11, latch cmd_mode/cmd_amount from the deb_* registers and go to ISSUE. If deb_req=1 and deb_amount=11, go to ERR.
  - ISSUE: cmd_valid=1. On cmd_valid&cmd_ready go to BUSY. A fall of req while in ISSUE is ignored; once offered, a command is never retracted.
  - BUSY: the timeout counter runs from 0. On cmd_done go to ACK. If the counter reaches TIMEOUT_CYCLES-1 without cmd_done, go to ERR. If cmd_done arrives in that same cycle, cmd_done wins.
  - ACK: ack_out=1. When deb_req=0, go to IDLE.
  - ERR: err_out=1, ack_out=0. When deb_req=0, go to IDLE.
- cmd_done outside BUSY is ignored.
- cmd_ready outside ISSUE is ignored.
- jog_mode equals deb_mode only when state=IDLE and deb_req=0; otherwise it is 3'b000.
- cmd_mode and cmd_amount hold their value from latch until the next latch.

## Timing
- Reset: all sync flops, deb_* registers and counters are 0, and the state is IDLE. cmd_valid, ack_out, err_out and busy are 0; cmd_mode, cmd_amount and jog_mode are 0.
- All outputs are registered, and state-derived outputs change in the cycle after the transition decision.
- Latency from a held input change to deb_* updated is SYNC_STAGES+STABLE_CYCLES cycles.
- Latency from req rise (other bits already stable) to cmd_valid=1 is SYNC_STAGES+STABLE_CYCLES+1 cycles.
- cmd_valid falls the cycle after the cycle where cmd_valid and cmd_ready are both high.
- ack_out rises the cycle after cmd_done. It falls SYNC_STAGES+STABLE_CYCLES+1 cycles after req falls.
- A new request is honoured only after the block has returned to IDLE. A req still high in IDLE is impossible because ACK and ERR both exit only on deb_req=0.
- Glitches shorter than STABLE_CYCLES never reach the deb_* registers.
- rst asserted in any state returns the block to IDLE with reset values on the next edge; a pending downstream command is simply dropped.

## Structure
- A shared package pi_cmd_pkg holds:
  - the state enum (IDLE, ISSUE, BUSY, ACK, ERR);
  - the amount codes AMT_SMALL, AMT_MED, AMT_LARGE, AMT_INVALID;
  - the mode code MODE_STOP=3'b000;
  - the bus width constant PI_BUS_W=6.
- One sub-module, bus_debounce, parameterised by width, SYNC_STAGES and STABLE_CYCLES, holds the synchroniser and stability counter. The FSM, timeout counter and command latch stay in pi_cmd_receiver.

## Test plan
Parameters for all scenarios: STABLE_CYCLES=4, TIMEOUT_CYCLES=100.
- Normal dispense: amount=01, mode=000, req 0→1, with cmd_ready tied high and cmd_done pulsed 10 cycles later. Expect cmd_valid for 1 cycle at cycle 7 after req, cmd_amount=01, and ack_out=1 the cycle after cmd_done. After req falls, ack_out=0 7 cycles later and busy=0.
- Glitch rejection: req pulses high for 3 cycles. Expect no cmd_valid, busy=0 and deb_req unchanged.
- Invalid amount: amount=11 with req high. Expect err_out=1, no cmd_valid, ack_out=0. After req is dropped, err_out clears.
- Backpressure: cmd_ready is held low for 20 cycles while req toggles low then high. Expect cmd_valid to stay high with a constant cmd_amount, then a transfer when cmd_ready rises.
- Timeout: the request is accepted and cmd_done never arrives. Expect err_out=1 exactly 100 cycles after entering BUSY. In a separate run, cmd_done on cycle 99 gives ack_out=1 and err_out=0.
- Jog and reset: with req=0 and mode=011, expect jog_mode=011 after 6 cycles. Assert rst while in BUSY: next cycle every output is 0 and the state is IDLE.
